// File: rtl/frame_pkg.sv
// frame_pkg: shared types for frame_commit_gen and its bench scoreboard
package frame_pkg;
  typedef enum logic [1:0] {IDLE, BODY, DROP} fcg_state_t;
  typedef enum logic [1:0] {V_NONE, V_COMMIT, V_REVERT} verdict_t;
endpackage

// File: rtl/frame_commit_gen.sv
// frame_commit_gen: speculative-FIFO producer that forwards frame payloads and pulses commit/revert per frame
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_last/in_err upstream beats;
// out_valid/out_ready/out_data speculative FIFO writes; commit/revert one-cycle frame verdicts.
// FRAME_STATS_EN adds saturating good_cnt/bad_cnt verdict counters.
module frame_commit_gen
  import frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             commit,
  output logic             revert
`ifdef FRAME_STATS_EN
  ,
  output logic [31:0]      good_cnt,
  output logic [31:0]      bad_cnt
`endif
);
  localparam int LW = $clog2(MAX_LEN + 1);
  fcg_state_t st, st_n;
  logic [WIDTH-1:0] sum, sum_n;
  logic [LW-1:0] len, len_n;
  logic live, full, payload, poison, term, good, acc;
  always_comb begin
    live = !reset && st != DROP;
    full = len == LW'(MAX_LEN);
    payload = live && !in_last && !in_err && !full;
    poison = live && !in_last && (in_err || full);
    term = live && in_last;
    in_ready = (reset || payload) ? out_ready : 1'b1;
    out_valid = payload && in_valid;
    out_data = in_data;
    good = term && !in_err && len != '0 && sum == in_data;
    commit = in_valid && good;
    revert = in_valid && (poison || (term && !good));
    acc = in_valid && in_ready;
    st_n = st;
    sum_n = sum;
    len_n = len;
    if (acc && payload) begin
      st_n = BODY;
      sum_n = sum + in_data;
      len_n = len + 1'b1;
    end else if (acc && poison) begin
      st_n = DROP;
      sum_n = '0;
      len_n = '0;
    end else if (acc && in_last) begin
      st_n = IDLE;
      sum_n = '0;
      len_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      sum <= '0;
      len <= '0;
    end else begin
      st <= st_n;
      sum <= sum_n;
      len <= len_n;
    end
  end
`ifdef FRAME_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      if (commit && !(&good_cnt)) good_cnt <= good_cnt + 1'b1;
      if (revert && !(&bad_cnt)) bad_cnt <= bad_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_frame_commit_gen.sv
// tb_frame_commit_gen: randomized and directed self-checking bench for frame_commit_gen
module tb_frame_commit_gen;
  import frame_pkg::*;
  localparam int MAXL = 4;
  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic r;
    logic v;
    logic [7:0] d;
    logic l;
    logic e;
    logic o;
  } beat_t;
  logic clk = 0, reset, in_valid, in_ready, in_last, in_err, out_valid, out_ready, commit, revert;
  logic [7:0] in_data, out_data;
`ifdef FRAME_STATS_EN
  logic [31:0] good_cnt, bad_cnt;
`endif
  int checks = 0, fails = 0, ngood = 0, nbad = 0;
  bit mdrop = 0;
  bytes_t mq, mdel, pend, seen;
  beat_t bq[$];
  always #5 clk = ~clk;
  frame_commit_gen #(.WIDTH(8), .MAX_LEN(MAXL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_err(in_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .commit(commit), .revert(revert)
`ifdef FRAME_STATS_EN
    , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );
  function automatic bit same(input bytes_t a, input bytes_t b);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction
  function automatic void add(input bit v, input logic [7:0] d, input bit l, input bit e = 0, input bit o = 1, input bit r = 0);
    bq.push_back('{r: r, v: v, d: d, l: l, e: e, o: o});
  endfunction
  function automatic void frame(input bytes_t p, input logic [7:0] ck);
    foreach (p[i]) add(1, p[i], 0);
    add(1, ck, 1);
  endfunction
  // Drives one cycle, returns the DUT's outputs and what the frame rules predict for them.
  task automatic step(input beat_t b, output logic [11:0] obs, output logic [11:0] exp);
    int s;
    verdict_t vd;
    logic rdy, ov;
    @(negedge clk);
    reset = b.r; in_valid = b.v; in_data = b.d; in_last = b.l; in_err = b.e; out_ready = b.o;
    #1;
    obs = {in_ready, out_valid, out_data, commit, revert};
    s = 0;
    foreach (mq[i]) s += int'(mq[i]);
    vd = V_NONE; rdy = 1; ov = 0;
    if (b.r) rdy = b.o;
    else if (mdrop) vd = V_NONE;
    else if (b.l) vd = (!b.e && mq.size() != 0 && s[7:0] == b.d) ? V_COMMIT : V_REVERT;
    else if (b.e || mq.size() == MAXL) vd = V_REVERT;
    else begin rdy = b.o; ov = b.v; end
    if (!b.v) vd = V_NONE;
    exp = {rdy, ov, b.d, vd == V_COMMIT, vd == V_REVERT};
    if (b.r) begin
      mq.delete(); mdrop = 0; ngood = 0; nbad = 0;
    end else if (b.v && rdy) begin
      if (mdrop) mdrop = !b.l;
      else if (vd == V_COMMIT) begin
        foreach (mq[i]) mdel.push_back(mq[i]);
        mq.delete(); ngood++;
      end else if (vd == V_REVERT) begin
        mq.delete(); mdrop = !b.l; nbad++;
      end else mq.push_back(b.d);
    end
    if (b.r) pend.delete();
    else begin
      if (out_valid && out_ready) pend.push_back(out_data);
      if (commit) begin
        foreach (pend[i]) seen.push_back(pend[i]);
        pend.delete();
      end else if (revert) pend.delete();
    end
  endtask
  task automatic test_reset();
    logic [11:0] o, x;
    bq.delete();
    add(1, 8'h55, 1, 0, 0, 1);
    add(1, 8'h56, 0, 1, 1, 1);
    add(1, 8'h57, 0, 0, 1, 1);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL reset cyc%0d got=%h want=%h", i, o, x); end
    end
    seen.delete();
  endtask
  task automatic test_good();
    logic [11:0] o, x;
    bytes_t want = '{8'h01, 8'h02, 8'h03};
    bq.delete();
    frame('{8'h01, 8'h02, 8'h03}, 8'h06);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL good beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL good_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_bad_checksum();
    logic [11:0] o, x;
    bytes_t want = '{8'h05};
    bq.delete();
    frame('{8'h10, 8'h20}, 8'h31);
    frame('{8'h05}, 8'h05);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL badsum beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL badsum_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_overflow();
    logic [11:0] o, x;
    bytes_t want = '{8'h09, 8'h0a};
    bq.delete();
    frame('{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA}, 8'hFC);
    frame('{8'h09, 8'h0a}, 8'h13);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL overflow beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL overflow_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_err_runt();
    logic [11:0] o, x;
    bytes_t want = '{};
    bq.delete();
    add(1, 8'h11, 0);
    add(1, 8'h22, 0, 1);
    add(1, 8'h33, 0);
    add(1, 8'h66, 1);
    add(1, 8'h00, 1);
    add(0, 8'h00, 1);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL err_runt beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL err_runt_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_backpressure();
    logic [11:0] o, x;
    bytes_t want = '{8'h07, 8'h08, 8'h09};
    bq.delete();
    add(1, 8'h07, 0);
    repeat (3) add(1, 8'h08, 0, 0, 0);
    add(1, 8'h08, 0);
    add(1, 8'h09, 0);
    add(1, 8'h18, 1, 0, 0);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL backpressure beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL backpressure_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_back_to_back();
    logic [11:0] o, x;
    bytes_t want = '{8'h01, 8'h02, 8'h06};
    bq.delete();
    frame('{8'h01, 8'h02}, 8'h03);
    frame('{8'h04}, 8'h05);
    frame('{8'h06}, 8'h06);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL b2b beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL b2b_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_reset_mid();
    logic [11:0] o, x;
    bytes_t want = '{8'h02};
    bq.delete();
    add(1, 8'h40, 0);
    add(1, 8'h41, 0);
    add(0, 8'h00, 0, 0, 1, 1);
    add(1, 8'h81, 1);
    frame('{8'h02}, 8'h02);
    foreach (bq[i]) begin
      step(bq[i], o, x); checks++;
      if (o !== x) begin fails++; $display("FAIL reset_mid beat%0d got=%h want=%h", i, o, x); end
    end
    checks++;
    if (!same(seen, want)) begin fails++; $display("FAIL reset_mid_consumer got=%p want=%p", seen, want); end
    seen.delete();
  endtask
  task automatic test_random();
    logic [11:0] o, x;
    logic [7:0] s;
    beat_t b;
    int n;
    mdel.delete(); seen.delete();
    repeat (150) begin
      n = $urandom_range(0, 6);
      s = 0;
      for (int i = 0; i <= n; i++) begin
        b.r = 0;
        b.l = (i == n);
        b.e = $urandom_range(0, 19) == 0;
        b.d = b.l ? ($urandom_range(0, 9) < 7 ? s : 8'($urandom)) : 8'($urandom);
        if (!b.l) s += b.d;
        do begin
          b.v = $urandom_range(0, 3) != 0;
          b.o = $urandom_range(0, 3) != 0;
          step(b, o, x); checks++;
          if (o !== x) begin fails++; $display("FAIL random beat got=%h want=%h", o, x); end
        end while (!(b.v && x[11]));
      end
    end
    checks++;
    if (!same(seen, mdel)) begin fails++; $display("FAIL random_consumer got_bytes=%0d want_bytes=%0d", seen.size(), mdel.size()); end
  endtask
  initial begin
    reset = 1; in_valid = 0; in_data = 0; in_last = 0; in_err = 0; out_ready = 1;
    test_reset();
    test_good();
    test_bad_checksum();
    test_overflow();
    test_err_runt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef FRAME_STATS_EN
    @(negedge clk);
    checks++;
    if (good_cnt !== 32'(ngood) || bad_cnt !== 32'(nbad)) begin
      fails++; $display("FAIL stats got=%0d/%0d want=%0d/%0d", good_cnt, bad_cnt, ngood, nbad);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
